// File: rtl/tl45_pkg.sv
// Shared TL45 pipeline definitions: bubble encodings and the fetch packet
// that moves from prefetch towards decode.
package tl45_pkg;

  localparam logic [31:0] TL45_NOP       = 32'h0;
  localparam logic [31:0] TL45_BUBBLE_PC = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } tl45_fetch_pkt_t;

  // An all-zero packet is the pipeline bubble; a NOP at PC 0 is dropped with it.
  function automatic logic is_bubble(input tl45_fetch_pkt_t pkt);
    return (pkt.pc == TL45_BUBBLE_PC) && (pkt.inst == TL45_NOP);
  endfunction

endpackage

// File: rtl/tl45_inst_queue.sv
// First-word-fall-through instruction queue between prefetch and decode.
// Absorbs fetch bursts and decouples decode stalls from the fetch FSM.
module tl45_inst_queue
  import tl45_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [31:0]      i_fetch_pc,
  input  logic [31:0]      i_fetch_inst,
  output logic             o_fetch_stall,
  input  logic             i_pipe_flush,
  input  logic             i_new_pc,
  output logic [31:0]      o_dec_pc,
  output logic [31:0]      o_dec_inst,
  output logic             o_dec_valid,
  input  logic             i_dec_stall,
  output logic [PTR_W:0]   o_count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  tl45_fetch_pkt_t [DEPTH-1:0] mem;
  tl45_fetch_pkt_t             fetch_pkt;
  tl45_fetch_pkt_t             head;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic flush;
  logic full;
  logic push;
  logic pop;

  assign fetch_pkt = {i_fetch_pc, i_fetch_inst};
  assign flush     = i_pipe_flush | i_new_pc;
  assign full      = (count == FULL_COUNT);

  // Stall and valid come only from the registered count, so decode's stall
  // never reaches prefetch combinationally.
  assign push = !full && !flush && !is_bubble(fetch_pkt);
  assign pop  = (count != '0) && !i_dec_stall && !flush;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; unread slots are never observed.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= fetch_pkt;
    end
  end

  assign head = mem[rd_ptr];

  assign o_count       = count;
  assign o_fetch_stall = full;
  assign o_dec_valid   = (count != '0);
  assign o_dec_pc      = o_dec_valid ? head.pc   : TL45_BUBBLE_PC;
  assign o_dec_inst    = o_dec_valid ? head.inst : TL45_NOP;

endmodule

// File: tb/tb_tl45_inst_queue.sv
// Scoreboard bench for tl45_inst_queue: the driver queues expected packets,
// a negedge monitor checks the head, occupancy and stall against a count model.
module tb_tl45_inst_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic              i_clk;
  logic              i_reset_n;
  logic [31:0]       i_fetch_pc;
  logic [31:0]       i_fetch_inst;
  logic              o_fetch_stall;
  logic              i_pipe_flush;
  logic              i_new_pc;
  logic [31:0]       o_dec_pc;
  logic [31:0]       o_dec_inst;
  logic              o_dec_valid;
  logic              i_dec_stall;
  logic [PTR_W:0]    o_count;

  int n_checks;
  int n_fail;
  int model_count;
  logic exp_push;
  logic [63:0] sb[$];

  tl45_inst_queue #(.DEPTH(DEPTH)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_fetch_pc   (i_fetch_pc),
    .i_fetch_inst (i_fetch_inst),
    .o_fetch_stall(o_fetch_stall),
    .i_pipe_flush (i_pipe_flush),
    .i_new_pc     (i_new_pc),
    .o_dec_pc     (o_dec_pc),
    .o_dec_inst   (o_dec_inst),
    .o_dec_valid  (o_dec_valid),
    .i_dec_stall  (i_dec_stall),
    .o_count      (o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares against the model, then advances it with the inputs
  // that will be sampled at the coming rising edge.
  always @(negedge i_clk) begin
    logic flush_now;
    logic bubble_now;
    logic push_now;
    logic pop_now;
    if (!i_reset_n) begin
      check_output("rst_count", 32'(o_count), 32'd0);
      check_output("rst_valid", 32'(o_dec_valid), 32'd0);
      check_output("rst_stall", 32'(o_fetch_stall), 32'd0);
      check_output("rst_pc", o_dec_pc, 32'h0);
      check_output("rst_inst", o_dec_inst, 32'h0);
      model_count = 0;
      exp_push = 1'b0;
      sb.delete();
    end else begin
      flush_now  = i_pipe_flush | i_new_pc;
      bubble_now = ({i_fetch_pc, i_fetch_inst} == 64'h0);
      check_output("count", 32'(o_count), 32'(model_count));
      check_output("valid", 32'(o_dec_valid), 32'(model_count != 0));
      check_output("fetch_stall", 32'(o_fetch_stall), 32'(model_count == DEPTH));
      if (model_count == 0) begin
        check_output("empty_pc", o_dec_pc, 32'h0);
        check_output("empty_inst", o_dec_inst, 32'h0);
      end else if (sb.size() == 0) begin
        check_output("sb_underflow", 32'(model_count), 32'd0);
      end else begin
        check_output("head_pc", o_dec_pc, sb[0][63:32]);
        check_output("head_inst", o_dec_inst, sb[0][31:0]);
      end
      push_now = (model_count != DEPTH) && !flush_now && !bubble_now;
      pop_now  = (model_count != 0) && !i_dec_stall && !flush_now;
      exp_push = push_now;
      if (flush_now) begin
        model_count = 0;
        sb.delete();
      end else begin
        if (pop_now && sb.size() > 0) void'(sb.pop_front());
        model_count = model_count + int'(push_now) - int'(pop_now);
      end
    end
  end

  // Drive one fetch pair, holding it until the model says it was taken.
  task automatic apply_stimulus(input logic [31:0] pc, input logic [31:0] inst);
    int waited;
    i_fetch_pc   = pc;
    i_fetch_inst = inst;
    if ({pc, inst} == 64'h0) begin
      @(posedge i_clk);
      #1;
    end else begin
      sb.push_back({pc, inst});
      waited = 0;
      do begin
        @(posedge i_clk);
        #1;
        waited++;
      end while (!exp_push_seen() && waited < 40);
      if (waited >= 40) check_output("accept_timeout", pc, 32'hFFFF_FFFF);
    end
    i_fetch_pc   = 32'h0;
    i_fetch_inst = 32'h0;
  endtask

  // exp_push is set at the negedge before the edge just passed.
  function automatic logic exp_push_seen();
    return last_push;
  endfunction

  logic last_push;
  always @(posedge i_clk) last_push <= exp_push;

  task automatic drain(input int cycles);
    for (int k = 0; k < cycles; k++) apply_stimulus(32'h0, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    model_count = 0;
    exp_push = 1'b0;
    i_reset_n = 1'b0;
    i_fetch_pc = 32'h0;
    i_fetch_inst = 32'h0;
    i_pipe_flush = 1'b0;
    i_new_pc = 1'b0;
    i_dec_stall = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_reset_n = 1'b1;

    // Streaming with decode free-running: count never exceeds 1.
    apply_stimulus(32'h100, 32'hA);
    apply_stimulus(32'h104, 32'hB);
    apply_stimulus(32'h108, 32'hC);
    drain(3);

    // Fill past depth; fifth pair is held by the stall.
    i_dec_stall = 1'b1;
    fork
      begin
        apply_stimulus(32'h200, 32'h20);
        apply_stimulus(32'h204, 32'h21);
        apply_stimulus(32'h208, 32'h22);
        apply_stimulus(32'h20C, 32'h23);
        apply_stimulus(32'h210, 32'h24);
      end
      begin
        repeat (6) @(posedge i_clk);
        #2;
        check_output("full_count", 32'(o_count), 32'd4);
        check_output("full_stall", 32'(o_fetch_stall), 32'd1);
        check_output("full_head", o_dec_pc, 32'h200);
        check_output("held_input", i_fetch_pc, 32'h210);
        i_dec_stall = 1'b0;
      end
    join
    drain(6);

    // Bubbles between two valid pairs are not enqueued.
    i_dec_stall = 1'b1;
    apply_stimulus(32'h300, 32'h30);
    apply_stimulus(32'h0, 32'h0);
    apply_stimulus(32'h0, 32'h0);
    apply_stimulus(32'h304, 32'h31);
    check_output("bubble_count", 32'(o_count), 32'd2);
    i_dec_stall = 1'b0;
    drain(4);

    // Redirect with three queued entries and a live input.
    i_dec_stall = 1'b1;
    apply_stimulus(32'h380, 32'h38);
    apply_stimulus(32'h384, 32'h39);
    apply_stimulus(32'h388, 32'h3A);
    i_fetch_pc = 32'h400;
    i_fetch_inst = 32'h40;
    i_new_pc = 1'b1;
    @(posedge i_clk);
    #1;
    i_new_pc = 1'b0;
    i_fetch_pc = 32'h0;
    i_fetch_inst = 32'h0;
    check_output("flush_count", 32'(o_count), 32'd0);
    check_output("flush_valid", 32'(o_dec_valid), 32'd0);
    check_output("flush_pc", o_dec_pc, 32'h0);
    i_dec_stall = 1'b0;
    apply_stimulus(32'h410, 32'h41);
    drain(3);

    // Simultaneous push and pop at count 2.
    i_dec_stall = 1'b1;
    apply_stimulus(32'h480, 32'h48);
    apply_stimulus(32'h484, 32'h49);
    i_dec_stall = 1'b0;
    apply_stimulus(32'h500, 32'h50);
    i_dec_stall = 1'b1;
    check_output("pushpop_count", 32'(o_count), 32'd2);
    check_output("pushpop_head", o_dec_pc, 32'h484);
    i_dec_stall = 1'b0;
    drain(4);

    // Asynchronous reset mid-cycle with three entries queued.
    i_dec_stall = 1'b1;
    apply_stimulus(32'h600, 32'h60);
    apply_stimulus(32'h604, 32'h61);
    apply_stimulus(32'h608, 32'h62);
    #2 i_reset_n = 1'b0;
    #1;
    check_output("async_count", 32'(o_count), 32'd0);
    check_output("async_valid", 32'(o_dec_valid), 32'd0);
    check_output("async_stall", 32'(o_fetch_stall), 32'd0);
    @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    i_dec_stall = 1'b0;
    apply_stimulus(32'h700, 32'h70);
    drain(3);

    check_output("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
